// File: rtl/bp_fe_bp_update_queue.sv
// Branch-predictor update queue: records each fetch-time prediction in order and,
// when the backend resolves the oldest branch, drives the predictor's update port
// one cycle later. Also keeps a saturating mispredict counter for perf monitoring.
module bp_fe_bp_update_queue
    #(parameter int unsigned bht_idx_width_p = 10
    , parameter int unsigned els_p           = 8
    , parameter int unsigned cnt_width_p     = 16
    , localparam int unsigned ptr_width_lp   = $clog2(els_p)
    )
    (input  logic                        clk_i
    , input  logic                       reset_i

    , input  logic                       pred_v_i
    , input  logic [bht_idx_width_p-1:0] pred_idx_i
    , input  logic                       pred_taken_i
    , output logic                       pred_ready_o

    , input  logic                       res_v_i
    , input  logic                       res_taken_i
    , output logic                       res_ready_o

    , input  logic                       flush_i

    , output logic                       w_v_o
    , output logic [bht_idx_width_p-1:0] idx_w_o
    , output logic                       correct_o

    , output logic [cnt_width_p-1:0]     mispredict_cnt_o
    , output logic                       empty_o
    );

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    typedef logic [ptr_width_lp:0]    ptr_t;
    typedef logic [cnt_width_p-1:0]   cnt_t;
    typedef logic [bht_idx_width_p-1:0] idx_t;

    typedef struct packed {
        idx_t idx;
        logic taken;
    } entry_s;

    entry_s mem_r [els_p];

    ptr_t   rptr_r, wptr_r;
    ptr_t   rptr_n, wptr_n;
    logic   full, empty;
    logic   enq_fire, deq_fire;
    entry_s head;

    logic   w_v_n;
    idx_t   idx_w_n;
    logic   correct_n;
    cnt_t   cnt_n;

    // Occupancy status derived purely from the registered pointers
    assign empty = (rptr_r == wptr_r);
    assign full  = (rptr_r[ptr_width_lp-1:0] == wptr_r[ptr_width_lp-1:0])
                && (rptr_r[ptr_width_lp]     != wptr_r[ptr_width_lp]);

    assign pred_ready_o = ~full;
    assign res_ready_o  = ~empty;
    assign empty_o      = empty;

    // A flush discards any enqueue offered in the same cycle; resolves still fire
    assign enq_fire = pred_v_i & ~full & ~flush_i;
    assign deq_fire = res_v_i  & ~empty;

    assign head = mem_r[rptr_r[ptr_width_lp-1:0]];

    // Next-state for pointers, the registered update port and the perf counter
    always_comb begin
        rptr_n    = rptr_r;
        wptr_n    = wptr_r;
        w_v_n     = 1'b0;
        idx_w_n   = idx_w_o;
        correct_n = correct_o;
        cnt_n     = mispredict_cnt_o;

        if (deq_fire) begin
            rptr_n = rptr_r + ptr_t'(1);
        end
        if (enq_fire) begin
            wptr_n = wptr_r + ptr_t'(1);
        end
        // Flush empties the queue by catching the read pointer up to the write pointer
        if (flush_i) begin
            rptr_n = wptr_r;
        end

        if (deq_fire) begin
            w_v_n     = 1'b1;
            idx_w_n   = head.idx;
            correct_n = (head.taken == res_taken_i);
            if (!correct_n && (mispredict_cnt_o != '1)) begin
                cnt_n = mispredict_cnt_o + cnt_t'(1);
            end
        end
    end

    // State registers; reset wins over flush, enqueue and resolve
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rptr_r           <= '0;
            wptr_r           <= '0;
            w_v_o            <= 1'b0;
            idx_w_o          <= '0;
            correct_o        <= 1'b0;
            mispredict_cnt_o <= '0;
        end else begin
            rptr_r           <= rptr_n;
            wptr_r           <= wptr_n;
            w_v_o            <= w_v_n;
            idx_w_o          <= idx_w_n;
            correct_o        <= correct_n;
            mispredict_cnt_o <= cnt_n;
        end
    end

    // Entry storage; contents need no reset since the pointers define validity
    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            mem_r[wptr_r[ptr_width_lp-1:0]] <= '{idx: pred_idx_i, taken: pred_taken_i};
        end
    end

endmodule

// File: tb/tb_bp_fe_bp_update_queue.sv
// Bench for bp_fe_bp_update_queue: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_bp_fe_bp_update_queue;

    localparam int unsigned IW  = 10;
    localparam int unsigned ELS = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_i = 1'b1;
    logic          pred_v_i = 1'b0;
    logic [IW-1:0] pred_idx_i = '0;
    logic          pred_taken_i = 1'b0;
    logic          res_v_i = 1'b0;
    logic          res_taken_i = 1'b0;
    logic          flush_i = 1'b0;

    logic          pred_ready, res_ready, w_v, correct, empty;
    logic [IW-1:0] idx_w;
    logic [15:0]   cnt;

    logic          pred_ready2, res_ready2, w_v2, correct2, empty2;
    logic [IW-1:0] idx_w2;
    logic [1:0]    cnt2;

    bp_fe_bp_update_queue #(.bht_idx_width_p(IW), .els_p(ELS), .cnt_width_p(16)) dut (
        .clk_i(clk), .reset_i(reset_i),
        .pred_v_i(pred_v_i), .pred_idx_i(pred_idx_i), .pred_taken_i(pred_taken_i),
        .pred_ready_o(pred_ready),
        .res_v_i(res_v_i), .res_taken_i(res_taken_i), .res_ready_o(res_ready),
        .flush_i(flush_i),
        .w_v_o(w_v), .idx_w_o(idx_w), .correct_o(correct),
        .mispredict_cnt_o(cnt), .empty_o(empty)
    );

    bp_fe_bp_update_queue #(.bht_idx_width_p(IW), .els_p(ELS), .cnt_width_p(2)) dut_sat (
        .clk_i(clk), .reset_i(reset_i),
        .pred_v_i(pred_v_i), .pred_idx_i(pred_idx_i), .pred_taken_i(pred_taken_i),
        .pred_ready_o(pred_ready2),
        .res_v_i(res_v_i), .res_taken_i(res_taken_i), .res_ready_o(res_ready2),
        .flush_i(flush_i),
        .w_v_o(w_v2), .idx_w_o(idx_w2), .correct_o(correct2),
        .mispredict_cnt_o(cnt2), .empty_o(empty2)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: an in-order list of outstanding predictions
    typedef struct {
        logic [IW-1:0] idx;
        logic          taken;
    } ent_t;

    ent_t          q[$];
    logic          exp_wv = 1'b0;
    logic [IW-1:0] exp_idx = '0;
    logic          exp_corr = 1'b0;
    int            exp_cnt = 0;
    int            exp_cnt2 = 0;

    function automatic void model_apply();
        ent_t e;
        bit   was_full;
        bit   fire;
        if (reset_i) begin
            q.delete();
            exp_wv = 1'b0; exp_idx = '0; exp_corr = 1'b0;
            exp_cnt = 0; exp_cnt2 = 0;
            return;
        end
        was_full = (q.size() == ELS);
        fire     = res_v_i && (q.size() != 0);
        exp_wv   = fire;
        if (fire) begin
            e = q.pop_front();
            exp_idx  = e.idx;
            exp_corr = (e.taken == res_taken_i);
            if (!exp_corr) begin
                if (exp_cnt < 65535) exp_cnt++;
                if (exp_cnt2 < 3) exp_cnt2++;
            end
        end
        if (flush_i) q.delete();
        else if (pred_v_i && !was_full) q.push_back('{pred_idx_i, pred_taken_i});
    endfunction

    task automatic cycle();
        model_apply();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic pv, input logic [IW-1:0] pidx, input logic pt,
                         input logic rv, input logic rt, input logic fl);
        pred_v_i = pv; pred_idx_i = pidx; pred_taken_i = pt;
        res_v_i = rv; res_taken_i = rt; flush_i = fl;
        cycle();
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        drive(0, '0, 0, 0, 0, 0);
        drive(0, '0, 0, 0, 0, 0);
        reset_i = 1'b0;
        checks++; if (w_v !== 1'b0) $display("FAIL reset_wv got %b exp 0", w_v); else passed++;
        checks++; if (idx_w !== '0) $display("FAIL reset_idx got %0d exp 0", idx_w); else passed++;
        checks++; if (correct !== 1'b0) $display("FAIL reset_correct got %b exp 0", correct); else passed++;
        checks++; if (cnt !== 16'd0) $display("FAIL reset_cnt got %0d exp 0", cnt); else passed++;
        checks++; if (pred_ready !== 1'b1) $display("FAIL reset_pred_ready got %b exp 1", pred_ready); else passed++;
        checks++; if (res_ready !== 1'b0) $display("FAIL reset_res_ready got %b exp 0", res_ready); else passed++;
        checks++; if (empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", empty); else passed++;
    endtask

    task automatic test_basic();
        drive(1, 10'd5, 1, 0, 0, 0);
        drive(1, 10'd9, 0, 0, 0, 0);
        drive(1, 10'd12, 1, 0, 0, 0);
        checks++; if (w_v !== 1'b0) $display("FAIL basic_no_update got %b exp 0", w_v); else passed++;
        drive(0, '0, 0, 1, 1, 0);
        checks++; if (w_v !== 1'b1 || idx_w !== 10'd5 || correct !== 1'b1)
            $display("FAIL basic_upd0 got v%b idx%0d c%b exp v1 idx5 c1", w_v, idx_w, correct); else passed++;
        drive(0, '0, 0, 1, 1, 0);
        checks++; if (w_v !== 1'b1 || idx_w !== 10'd9 || correct !== 1'b0)
            $display("FAIL basic_upd1 got v%b idx%0d c%b exp v1 idx9 c0", w_v, idx_w, correct); else passed++;
        drive(0, '0, 0, 1, 0, 0);
        checks++; if (w_v !== 1'b1 || idx_w !== 10'd12 || correct !== 1'b0)
            $display("FAIL basic_upd2 got v%b idx%0d c%b exp v1 idx12 c0", w_v, idx_w, correct); else passed++;
        drive(0, '0, 0, 0, 0, 0);
        checks++; if (w_v !== 1'b0) $display("FAIL basic_idle_wv got %b exp 0", w_v); else passed++;
        checks++; if (cnt !== 16'd2) $display("FAIL basic_cnt got %0d exp 2", cnt); else passed++;
        checks++; if (empty !== 1'b1) $display("FAIL basic_empty got %b exp 1", empty); else passed++;
    endtask

    task automatic test_full();
        for (int i = 0; i < ELS; i++) drive(1, IW'(100 + i), 1'(i), 0, 0, 0);
        checks++; if (pred_ready !== 1'b0) $display("FAIL full_ready got %b exp 0", pred_ready); else passed++;
        checks++; if (res_ready !== 1'b1) $display("FAIL full_res_ready got %b exp 1", res_ready); else passed++;
        drive(1, 10'd999, 1, 0, 0, 0);
        checks++; if (pred_ready !== 1'b0 || w_v !== 1'b0)
            $display("FAIL full_ninth got ready%b wv%b exp ready0 wv0", pred_ready, w_v); else passed++;
        drive(1, 10'd777, 0, 1, 1, 0);
        checks++; if (w_v !== 1'b1 || idx_w !== 10'd100)
            $display("FAIL full_pop got v%b idx%0d exp v1 idx100", w_v, idx_w); else passed++;
        checks++; if (pred_ready !== 1'b1) $display("FAIL full_ready_after got %b exp 1", pred_ready); else passed++;
        for (int i = 1; i < ELS; i++) begin
            drive(0, '0, 0, 1, 1, 0);
            checks++; if (w_v !== 1'b1 || idx_w !== IW'(100 + i))
                $display("FAIL full_drain%0d got v%b idx%0d exp v1 idx%0d", i, w_v, idx_w, 100 + i); else passed++;
        end
        checks++; if (empty !== 1'b1) $display("FAIL full_drained_empty got %b exp 1", empty); else passed++;
        checks++; if (cnt !== 16'(exp_cnt)) $display("FAIL full_cnt got %0d exp %0d", cnt, exp_cnt); else passed++;
    endtask

    task automatic test_stream();
        drive(1, IW'($urandom), 1'($urandom), 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            drive(1, IW'($urandom), 1'($urandom), 1, 1'($urandom), 0);
            checks++; if (w_v !== 1'b1 || idx_w !== exp_idx || correct !== exp_corr)
                $display("FAIL stream%0d got v%b idx%0d c%b exp v1 idx%0d c%b", i, w_v, idx_w, correct, exp_idx, exp_corr); else passed++;
            checks++; if (pred_ready !== 1'b1 || res_ready !== 1'b1 || empty !== 1'b0)
                $display("FAIL stream_occ%0d got pr%b rr%b e%b exp 1 1 0", i, pred_ready, res_ready, empty); else passed++;
        end
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom), IW'($urandom), 1'($urandom), 1'($urandom_range(0, 2) != 0),
                  1'($urandom), 1'($urandom_range(0, 15) == 0));
            checks++; if (w_v !== exp_wv || idx_w !== exp_idx || correct !== exp_corr)
                $display("FAIL rand_upd%0d got v%b idx%0d c%b exp v%b idx%0d c%b", i, w_v, idx_w, correct, exp_wv, exp_idx, exp_corr); else passed++;
            checks++; if (pred_ready !== (q.size() != ELS) || res_ready !== (q.size() != 0) || empty !== (q.size() == 0))
                $display("FAIL rand_occ%0d got pr%b rr%b e%b exp occupancy %0d", i, pred_ready, res_ready, empty, q.size()); else passed++;
            checks++; if (cnt !== 16'(exp_cnt) || cnt2 !== 2'(exp_cnt2))
                $display("FAIL rand_cnt%0d got %0d/%0d exp %0d/%0d", i, cnt, cnt2, exp_cnt, exp_cnt2); else passed++;
        end
    endtask

    task automatic test_flush();
        drive(0, '0, 0, 0, 0, 1);
        drive(1, 10'd7, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(1, IW'($urandom), 1'($urandom), 0, 0, 0);
        drive(1, 10'd55, 1, 1, 0, 1);
        checks++; if (w_v !== 1'b1 || idx_w !== 10'd7 || correct !== 1'b0)
            $display("FAIL flush_upd got v%b idx%0d c%b exp v1 idx7 c0", w_v, idx_w, correct); else passed++;
        checks++; if (empty !== 1'b1 || res_ready !== 1'b0)
            $display("FAIL flush_empty got e%b rr%b exp e1 rr0", empty, res_ready); else passed++;
        drive(0, '0, 0, 1, 1, 0);
        checks++; if (w_v !== 1'b0 || empty !== 1'b1)
            $display("FAIL flush_after got v%b e%b exp v0 e1", w_v, empty); else passed++;
        checks++; if (cnt !== 16'(exp_cnt)) $display("FAIL flush_cnt got %0d exp %0d", cnt, exp_cnt); else passed++;
    endtask

    task automatic test_res_empty();
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 0, 1, 1'($urandom), 0);
            checks++; if (w_v !== 1'b0 || empty !== 1'b1 || pred_ready !== 1'b1)
                $display("FAIL res_empty%0d got v%b e%b pr%b exp v0 e1 pr1", i, w_v, empty, pred_ready); else passed++;
        end
        drive(1, 10'd321, 0, 1, 0, 0);
        checks++; if (w_v !== 1'b0 || empty !== 1'b0)
            $display("FAIL res_same_cycle got v%b e%b exp v0 e0", w_v, empty); else passed++;
        drive(0, '0, 0, 1, 0, 0);
        checks++; if (w_v !== 1'b1 || idx_w !== 10'd321 || correct !== 1'b1 || empty !== 1'b1)
            $display("FAIL res_after got v%b idx%0d c%b e%b exp v1 idx321 c1 e1", w_v, idx_w, correct, empty); else passed++;
    endtask

    task automatic test_saturate();
        reset_i = 1'b1;
        drive(0, '0, 0, 0, 0, 0);
        reset_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1, IW'(i), 1, 0, 0, 0);
            drive(0, '0, 0, 1, 0, 0);
        end
        drive(0, '0, 0, 0, 0, 0);
        checks++; if (cnt2 !== 2'd3) $display("FAIL sat_cnt2 got %0d exp 3", cnt2); else passed++;
        checks++; if (cnt !== 16'd5) $display("FAIL sat_cnt16 got %0d exp 5", cnt); else passed++;
    endtask

    task automatic test_reset_mid();
        drive(1, 10'd40, 1, 0, 0, 0);
        drive(1, 10'd41, 0, 0, 0, 0);
        drive(1, 10'd42, 0, 1, 0, 0);
        checks++; if (w_v !== 1'b1 || idx_w !== 10'd40)
            $display("FAIL rmid_upd got v%b idx%0d exp v1 idx40", w_v, idx_w); else passed++;
        reset_i = 1'b1;
        drive(0, '0, 0, 1, 0, 0);
        reset_i = 1'b0;
        checks++; if (w_v !== 1'b0 || empty !== 1'b1 || pred_ready !== 1'b1 || cnt !== 16'd0 || cnt2 !== 2'd0)
            $display("FAIL rmid_state got v%b e%b pr%b cnt%0d/%0d exp v0 e1 pr1 cnt0/0", w_v, empty, pred_ready, cnt, cnt2); else passed++;
        drive(0, '0, 0, 1, 0, 0);
        checks++; if (w_v !== 1'b0 || empty !== 1'b1)
            $display("FAIL rmid_after got v%b e%b exp v0 e1", w_v, empty); else passed++;
        drive(1, 10'd60, 1, 0, 0, 0);
        drive(1, 10'd61, 1, 0, 0, 0);
        reset_i = 1'b1;
        drive(0, '0, 0, 1, 0, 0);
        reset_i = 1'b0;
        checks++; if (w_v !== 1'b0 || empty !== 1'b1 || idx_w !== '0)
            $display("FAIL rmid_suppress got v%b e%b idx%0d exp v0 e1 idx0", w_v, empty, idx_w); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_stream();
        test_flush();
        test_res_empty();
        test_saturate();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/bp_fe_bp_update_queue.md
Name: bp_fe_bp_update_queue

Overview:
- Producer side of the branch predictor's write (update) interface.
- Records each prediction issued at fetch (BHT index + predicted direction) in an in-order queue. When the backend resolves the oldest outstanding branch, it retires that entry and drives the predictor's w_v/idx_w/correct update port one cycle later.
- Sits in bp_fe between the fetch PC-gen logic and the predictor wrapper. Also keeps a saturating mispredict counter for perf monitoring.

Parameters:
- bht_idx_width_p, "inv", width of the BHT index; must match the predictor instance.
- els_p, 8, queue depth in outstanding branches; power of two, >= 2.
- ptr_width_lp (localparam), $clog2(els_p), read/write pointer width, excluding the wrap bit.
- cnt_width_p, 16, width of the mispredict counter.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- pred_v_i  in  1  fetch issued a prediction this cycle
- pred_idx_i  in  bht_idx_width_p  BHT index used for the prediction
- pred_taken_i  in  1  predicted direction (1 = taken)
- pred_ready_o  out  1  queue can accept a prediction
- res_v_i  in  1  backend resolved the oldest outstanding branch
- res_taken_i  in  1  actual direction
- res_ready_o  out  1  at least one entry outstanding
- flush_i  in  1  discard all outstanding entries (pipeline redirect)
- w_v_o  out  1  update valid; connects to the predictor's w_v_i
- idx_w_o  out  bht_idx_width_p  update index; connects to idx_w_i
- correct_o  out  1  prediction was correct; connects to correct_i
- mispredict_cnt_o  out  cnt_width_p  saturating count of mispredicts
- empty_o  out  1  no outstanding entries

Behaviour:
- Storage: els_p entries of {idx, taken}, held in registers (no SRAM).
- Pointers: rptr and wptr, each ptr_width_lp+1 bits including the wrap bit.
  - Empty when rptr == wptr.
  - Full when the low bits are equal and the wrap bits differ.
  - Pointers wrap naturally modulo 2*els_p.
- pred_ready_o = ~full, combinational from registered state. There is no bypass: when full, ready stays 0 even if a resolve is popping in the same cycle.
- Enqueue fires when pred_v_i & pred_ready_o: writes entry[wptr] and increments wptr. pred_v_i while not ready is dropped, and fetch must hold it.
- res_ready_o = ~empty.
  - Resolve fires when res_v_i & res_ready_o: reads entry[rptr] and increments rptr.
  - res_v_i while empty is ignored: no update, no pointer change.
  - An entry enqueued in cycle N is resolvable no earlier than cycle N+1.
- Update output is registered, one cycle latency. On a resolve firing in cycle N, the cycle N+1 outputs are:
  - w_v_o = 1
  - idx_w_o = entry.idx
  - correct_o = (entry.taken == res_taken_i)
- When no resolve fires in cycle N:
  - w_v_o = 0 in cycle N+1.
  - idx_w_o and correct_o hold their previous values (don't-care while w_v_o = 0).
- Mispredict counter: increments in the same cycle the registered update carries correct = 0. It saturates at all-ones and never wraps.
- Simultaneous enqueue + resolve, not full and not empty: both fire and the occupancy is unchanged.
- flush_i:
  - At the next edge, rptr is set to wptr (queue empties); entry contents are not cleared.
  - An enqueue in the same cycle is discarded.
  - A resolve in the same cycle still fires and produces its update in N+1 (a mispredict typically causes the flush).
  - The mispredict counter is not affected.
- Reset, which has priority over everything, sets:
  - rptr = wptr = 0
  - w_v_o = 0, idx_w_o = 0, correct_o = 0
  - mispredict_cnt_o = 0
  - Consequently pred_ready_o = 1, res_ready_o = 0, empty_o = 1.
  - Reset mid-operation discards all entries, and any update that would have issued in the next cycle is suppressed.
- No state machine beyond the pointers; the occupancy derived from them is the state.

Test Plan:
- Reset, then 3 enqueues (idx 5/T, 9/NT, 12/T), then 3 resolves (T, T, NT) -> updates in order:
  - (5, correct 1), (9, correct 0), (12, correct 0), each one cycle after its resolve;
  - mispredict_cnt_o = 2.
- Fill to 8 entries with els_p = 8 -> pred_ready_o = 0.
  - A 9th pred_v_i is not stored.
  - Resolve + enqueue in the same cycle -> only the resolve fires, and pred_ready_o = 1 the next cycle.
- Enqueue/resolve streaming for 20 cycles (wraps twice) -> every update's idx matches its enqueue order and the wrap bit produces no false full/empty.
- 4 entries outstanding, then flush_i with a simultaneous resolve (idx 7 predicted T, actual NT) -> one update (7, correct 0) next cycle, then empty_o = 1 and res_v_i ignored.
- res_v_i while empty -> w_v_o stays 0 and pointers are unchanged.
- With cnt_width_p = 2, 5 mispredicts -> mispredict_cnt_o = 3 (saturated).
- reset_i asserted the cycle after a resolve -> w_v_o = 0 and queue empty.
